// File: rtl/spi_pkg.sv
// Shared state type and constants for the SPI byte engine and its helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  localparam int unsigned SPI_BITS  = 8;
  localparam int unsigned SPI_EDGES = 2 * SPI_BITS;
  localparam logic        MOSI_IDLE = 1'b1;
  localparam logic [4:0]  LAST_EDGE = 5'(SPI_EDGES - 1);

  // Toggle numbers are 1-based; odd toggles are rising sck edges in mode 0.
  function automatic logic is_rising_toggle(input logic [4:0] toggle_num);
    return toggle_num[0];
  endfunction

endpackage

// File: rtl/spi_half_bit_tick.sv
// Free-running 0..H-1 counter while enabled; emits a one-cycle tick on the wrap cycle.
// Cleared whenever disabled, so the first tick lands H cycles after enable rises.
module spi_half_bit_tick #(
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic en_i,
  output logic tick_o
);

  if (CLKS_PER_HALF_BIT < 2 || CLKS_PER_HALF_BIT > 255) begin : g_bad_half_bit
    $error("CLKS_PER_HALF_BIT must lie in 2..255");
  end

  localparam logic [7:0] WRAP = 8'(CLKS_PER_HALF_BIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear while disabled, wrap at H-1.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = 8'd0;
    end else if (cnt_q == WRAP) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == WRAP);

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte master: one byte out on mosi and one in from miso per accepted request.
// Define SPI_CS_EN to add a hardware chip select (cs_n) with a cs_hold input.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
`ifdef SPI_CS_EN
  ,
  output logic       cs_n,
  input  logic       cs_hold
`endif
);

  spi_state_e state_q;
  logic [6:0] tx_sh_q;
  logic [7:0] rx_sh_q;
  logic [4:0] edge_q;
  logic       tx_ready_q;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;
  logic       sck_q;
  logic       mosi_q;

  logic       shift_en;
  logic       tick;
  logic       accept;
  logic [4:0] edge_inc;

  assign shift_en = (state_q == SHIFT);
  assign accept   = (state_q == IDLE) && tx_valid && tx_ready_q;
  assign edge_inc = edge_q + 5'd1;

  spi_half_bit_tick #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_half_bit_tick (
    .clk_i   (clk),
    .resetn_i(resetn),
    .en_i    (shift_en),
    .tick_o  (tick)
  );

  // Byte FSM with shift registers and all registered SPI/handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tx_sh_q    <= 7'd0;
      rx_sh_q    <= 8'd0;
      edge_q     <= 5'd0;
      tx_ready_q <= 1'b1;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= MOSI_IDLE;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= SHIFT;
            tx_sh_q    <= tx_byte[6:0];
            mosi_q     <= tx_byte[7];
            tx_ready_q <= 1'b0;
            edge_q     <= 5'd0;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            edge_q <= edge_inc;
            if (is_rising_toggle(edge_inc)) begin
              sck_q   <= 1'b1;
              rx_sh_q <= {rx_sh_q[6:0], miso};
            end else if (edge_q == LAST_EDGE) begin
              // Final falling edge: the eighth sample is already in rx_sh_q.
              sck_q      <= 1'b0;
              mosi_q     <= MOSI_IDLE;
              rx_byte_q  <= rx_sh_q;
              rx_valid_q <= 1'b1;
              edge_q     <= 5'd0;
              state_q    <= DONE;
            end else begin
              sck_q   <= 1'b0;
              mosi_q  <= tx_sh_q[6];
              tx_sh_q <= {tx_sh_q[5:0], 1'b0};
            end
          end else begin
            edge_q <= edge_q;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          tx_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          tx_ready_q <= 1'b1;
          sck_q      <= 1'b0;
          mosi_q     <= MOSI_IDLE;
          edge_q     <= 5'd0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;

`ifdef SPI_CS_EN
  logic cs_n_q;

  // Chip select: drops on acceptance, released only from IDLE once cs_hold clears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_n_q <= 1'b1;
    end else if (accept) begin
      cs_n_q <= 1'b0;
    end else if ((state_q == IDLE) && !cs_hold) begin
      cs_n_q <= 1'b1;
    end else begin
      cs_n_q <= cs_n_q;
    end
  end

  assign cs_n = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_byte_engine.sv
// Self-checking bench: two engines (H=2 and H=4) driven one at a time, checked
// against timing and data expectations derived from the byte-transfer rules.
`timescale 1ns/1ps
module tb_spi_byte_engine;

  localparam int unsigned H0 = 2;
  localparam int unsigned H1 = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_byte;
  logic       tx_valid0, tx_valid1;
  logic       tx_ready0, tx_ready1;
  logic       rx_valid0, rx_valid1;
  logic [7:0] rx_byte0, rx_byte1;
  logic       sck0, sck1, mosi0, mosi1;
  logic       miso;
`ifdef SPI_CS_EN
  logic       cs_n0, cs_n1, cs_hold;
`endif

  always #5 clk = ~clk;

  spi_byte_engine #(.CLKS_PER_HALF_BIT(H0)) u_dut0 (
    .clk(clk), .resetn(resetn), .tx_byte(tx_byte), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_byte(rx_byte0), .rx_valid(rx_valid0),
    .sck(sck0), .mosi(mosi0), .miso(miso)
`ifdef SPI_CS_EN
    , .cs_n(cs_n0), .cs_hold(cs_hold)
`endif
  );

  spi_byte_engine #(.CLKS_PER_HALF_BIT(H1)) u_dut1 (
    .clk(clk), .resetn(resetn), .tx_byte(tx_byte), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_byte(rx_byte1), .rx_valid(rx_valid1),
    .sck(sck1), .mosi(mosi1), .miso(miso)
`ifdef SPI_CS_EN
    , .cs_n(cs_n1), .cs_hold(cs_hold)
`endif
  );

  // Selected-DUT views and the slave model (loopback or shifting pattern).
  bit         sel;
  bit         loop_en;
  logic [7:0] slave_sh;
  logic       rdy_s, rxv_s, sck_s, mosi_s;
  logic [7:0] rxb_s;
  assign rdy_s  = sel ? tx_ready1 : tx_ready0;
  assign rxv_s  = sel ? rx_valid1 : rx_valid0;
  assign rxb_s  = sel ? rx_byte1  : rx_byte0;
  assign sck_s  = sel ? sck1      : sck0;
  assign mosi_s = sel ? mosi1     : mosi0;
  assign miso   = loop_en ? mosi_s : slave_sh[7];
`ifdef SPI_CS_EN
  logic cs_n_s;
  assign cs_n_s = sel ? cs_n1 : cs_n0;
`endif

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Event log, filled at the falling clock edge.
  int unsigned acc_q[$];
  int unsigned rdy_q[$];
  int unsigned rxv_q[$];
  logic [7:0]  rxb_q[$];
  int          rises, viol, cs_viol;
  logic [7:0]  mosi_cap;
  logic        p_rdy = 1'b1, p_sck = 1'b0, p_mosi = 1'b1;

  always @(negedge clk) begin
    if (resetn) begin
      if (p_rdy && !rdy_s) acc_q.push_back(edge_n);
      if (!p_rdy && rdy_s) rdy_q.push_back(edge_n);
      if (rxv_s) begin
        rxv_q.push_back(edge_n);
        rxb_q.push_back(rxb_s);
      end
      if (!p_sck && sck_s) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], mosi_s};
        slave_sh = {slave_sh[6:0], 1'b0};
      end
      if ((mosi_s != p_mosi) && sck_s) viol++;
`ifdef SPI_CS_EN
      if (!rdy_s && cs_n_s) cs_viol++;
`endif
    end
    p_rdy  = rdy_s;
    p_sck  = sck_s;
    p_mosi = mosi_s;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_valid(input logic v);
    if (sel) tx_valid1 = v;
    else     tx_valid0 = v;
  endtask

  task automatic clear_log();
    acc_q.delete(); rdy_q.delete(); rxv_q.delete(); rxb_q.delete();
    rises = 0; viol = 0; cs_viol = 0; mosi_cap = 8'h00;
  endtask

  // One transfer: byte b out, pattern p from the slave (or loopback), optional busy noise.
  task automatic xfer(input logic [7:0] b, input logic [7:0] p, input bit lb, input bit noisy);
    int unsigned h, a, n;
    logic [7:0]  exp_rx;
    h      = sel ? H1 : H0;
    exp_rx = lb ? b : p;
    clear_log();
    slave_sh = p;
    loop_en  = lb;
    tx_byte  = b;
    drive_valid(1'b1);
    step();
    drive_valid(1'b0);
    tx_byte = 8'($urandom);
    n = 0;
    while (rdy_q.size() == 0 && n < 16 * h + 20) begin
      if (noisy && !rdy_s) begin
        drive_valid(1'($urandom));
        tx_byte = 8'($urandom);
      end
      step();
      n++;
    end
    drive_valid(1'b0);
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    check_val("accept_count", 32'(acc_q.size()), 32'd1);
    check_val("rx_valid_count", 32'(rxv_q.size()), 32'd1);
    check_val("rx_valid_latency", (rxv_q.size() > 0) ? 32'(rxv_q[0] - a) : 32'hFFFF, 32'(16 * h));
    check_val("tx_ready_latency", (rdy_q.size() > 0) ? 32'(rdy_q[0] - a) : 32'hFFFF, 32'(16 * h + 1));
    check_val("rx_byte_at_valid", (rxb_q.size() > 0) ? 32'(rxb_q[0]) : 32'hFFFF, 32'(exp_rx));
    check_val("rx_byte_hold", 32'(rxb_s), 32'(exp_rx));
    check_val("sck_rises", 32'(rises), 32'd8);
    check_val("mosi_bits", 32'(mosi_cap), 32'(b));
    check_val("mosi_change_sck_high", 32'(viol), 32'd0);
    check_val("sck_idle", 32'(sck_s), 32'd0);
    check_val("mosi_idle", 32'(mosi_s), 32'd1);
`ifdef SPI_CS_EN
    check_val("cs_low_in_byte", 32'(cs_viol), 32'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    resetn = 1'b0; tx_byte = 8'h00; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
    sel = 1'b0; loop_en = 1'b0; slave_sh = 8'h00;
`ifdef SPI_CS_EN
    cs_hold = 1'b0;
`endif
    step(); step();
    resetn = 1'b1;
    step();

    check_val("rst_tx_ready0", 32'(tx_ready0), 32'd1);
    check_val("rst_rx_valid0", 32'(rx_valid0), 32'd0);
    check_val("rst_rx_byte0", 32'(rx_byte0), 32'h00);
    check_val("rst_sck0", 32'(sck0), 32'd0);
    check_val("rst_mosi0", 32'(mosi0), 32'd1);
    check_val("rst_tx_ready1", 32'(tx_ready1), 32'd1);
    check_val("rst_sck1", 32'(sck1), 32'd0);
`ifdef SPI_CS_EN
    check_val("rst_cs_n0", 32'(cs_n0), 32'd1);
`endif

    // Directed H=2 cases: loopback, miso stuck low, miso stuck high.
    sel = 1'b0;
    xfer(8'hA5, 8'h00, 1'b1, 1'b0);
    xfer(8'hFF, 8'h00, 1'b0, 1'b0);
    xfer(8'h00, 8'hFF, 1'b0, 1'b0);

    // Randomized bytes and slave patterns with busy-time tx_valid noise.
    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // tx_valid held high across two bytes.
    clear_log();
    loop_en = 1'b1;
    tx_byte = 8'h3C;
    drive_valid(1'b1);
    step();
    tx_byte = 8'hC3;
    n = 0;
    while (acc_q.size() < 2 && n < 100) begin step(); n++; end
    tx_byte = 8'($urandom);
    drive_valid(1'b0);
    n = 0;
    while (rdy_q.size() < 2 && n < 100) begin step(); n++; end
    check_val("b2b_accepts", 32'(acc_q.size()), 32'd2);
    check_val("b2b_period", (acc_q.size() > 1) ? 32'(acc_q[1] - acc_q[0]) : 32'hFFFF, 32'(16 * H0 + 2));
    check_val("b2b_rx_valid_count", 32'(rxv_q.size()), 32'd2);
    check_val("b2b_byte0", (rxb_q.size() > 0) ? 32'(rxb_q[0]) : 32'hFFFF, 32'h3C);
    check_val("b2b_byte1", (rxb_q.size() > 1) ? 32'(rxb_q[1]) : 32'hFFFF, 32'hC3);
    check_val("b2b_rises", 32'(rises), 32'd16);

    // Reset asserted mid-transfer.
    clear_log();
    loop_en = 1'b1;
    tx_byte = 8'hA5;
    drive_valid(1'b1);
    step();
    drive_valid(1'b0);
    repeat (9) step();
    resetn = 1'b0;
    #1;
    check_val("abort_sck", 32'(sck0), 32'd0);
    check_val("abort_mosi", 32'(mosi0), 32'd1);
    check_val("abort_tx_ready", 32'(tx_ready0), 32'd1);
    check_val("abort_rx_valid", 32'(rx_valid0), 32'd0);
    check_val("abort_rx_byte", 32'(rx_byte0), 32'h00);
    step(); step();
    resetn = 1'b1;
    repeat (40) step();
    check_val("abort_no_rx_valid", 32'(rxv_q.size()), 32'd0);
    xfer(8'h5A, 8'h00, 1'b1, 1'b0);

    // H=4 engine.
    sel = 1'b1;
    xfer(8'h81, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      xfer(8'($urandom), 8'($urandom), 1'b0, 1'b1);
    end
    sel = 1'b0;

`ifdef SPI_CS_EN
    // Chip select held across two bytes, then released.
    cs_hold = 1'b1;
    xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    repeat (3) step();
    check_val("cs_held_between", 32'(cs_n0), 32'd0);
    xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    check_val("cs_held_after_ready", 32'(cs_n0), 32'd0);
    cs_hold = 1'b0;
    step();
    check_val("cs_released", 32'(cs_n0), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
